coremacfilter_fcsstrip: RTL and testbench

COREMACFILTER_FCSSTRIP -- requirements
Module: coremacfilter_fcsstrip

---
 rtl/coremacfilter_fcsstrip_pkg.sv | 23 ++
 rtl/coremacfilter_fcsstrip_fcsdly.sv | 28 ++
 rtl/coremacfilter_fcsstrip.sv | 146 ++++++++++++++
 tb/tb_coremacfilter_fcsstrip.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/coremacfilter_fcsstrip_pkg.sv
// Shared definitions for the FCS-stripping receive filter.
package coremacfilter_fcsstrip_pkg;

   localparam int unsigned FCS_LEN    = 4;
   localparam int unsigned LEN_W      = 11;
   localparam int unsigned MINLEN_DEF = 64;
   localparam int unsigned MAXLEN_DEF = 1518;

   localparam logic [LEN_W-1:0] LEN_SAT = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_PASS  = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   typedef struct packed {
      logic       sof;
      logic [7:0] dat;
   } dly_ent_t;

endpackage

// File: rtl/coremacfilter_fcsstrip_fcsdly.sv
// FCS_LEN-deep byte delay line; the tail entry is the byte leaving the line on the next shift.
module coremacfilter_fcsdly
   import coremacfilter_fcsstrip_pkg::*;
(
   input  logic       cclk,
   input  logic       crstn,
   input  logic       shift,
   input  logic [7:0] dat,
   input  logic       sof,
   output logic [7:0] tail_dat,
   output logic       tail_sof
);

   dly_ent_t line [FCS_LEN];

   always_ff @(posedge cclk) begin
      if (!crstn) begin
         for (int i = 0; i < int'(FCS_LEN); i++) line[i] <= '0;
      end else if (shift) begin
         line[0] <= '{sof: sof, dat: dat};
         for (int i = 1; i < int'(FCS_LEN); i++) line[i] <= line[i-1];
      end
   end

   assign tail_dat = line[FCS_LEN-1].dat;
   assign tail_sof = line[FCS_LEN-1].sof;

endmodule

// File: rtl/coremacfilter_fcsstrip.sv
// Receive filter: strips the trailing FCS, drives an external CRC engine and reports
// per-frame status (CRC error, runt, long, abort, length).
module coremacfilter_fcsstrip
   import coremacfilter_fcsstrip_pkg::*;
#(
   parameter int unsigned TP     = 1,
   parameter int unsigned MINLEN = MINLEN_DEF,
   parameter int unsigned MAXLEN = MAXLEN_DEF
) (
   input  logic             cclk,
   input  logic             crstn,
   input  logic             xcen,
   input  logic [7:0]       rdat,
   input  logic             rval,
   input  logic             rsof,
   input  logic             reof,
   output logic [7:0]       cdat,
   output logic             cval,
   output logic             cini,
   output logic             chld,
   input  logic             cerr,
   output logic [7:0]       odat,
   output logic             oval,
   output logic             osof,
   output logic             oeof,
   output logic             sval,
   output logic             scrc,
   output logic             srnt,
   output logic             slng,
   output logic             sabt,
   output logic [LEN_W-1:0] slen
);

   // TP only shaped register delays in legacy simulation flows; registers here are zero-delay.
   if (TP > 0) begin : g_tp
   end

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len, pend_len, stat_len;
   logic             pend, push, restart, abort, emit, stat_fire;
   logic [7:0]       tail_dat;
   logic             tail_sof;

   always_ff @(posedge cclk) begin
      if (!crstn)    state <= ST_IDLE;
      else if (xcen) state <= state_nxt;
   end

   // Next state, CRC engine controls and per-byte datapath strobes.
   always_comb begin
      state_nxt = state;
      cini      = 1'b0;
      cval      = 1'b0;
      push      = 1'b0;
      restart   = 1'b0;
      abort     = 1'b0;
      emit      = 1'b0;
      case (state)
         ST_IDLE: begin
            cini = !(rval & rsof);
            cval = rval & rsof;
            if (rval & rsof) begin
               push      = 1'b1;
               restart   = 1'b1;
               state_nxt = reof ? ST_CHECK : ST_FILL;
            end
         end
         ST_FILL, ST_PASS: begin
            cval = rval;
            if (rval) begin
               push = 1'b1;
               if (rsof) begin
                  abort     = 1'b1;
                  restart   = 1'b1;
                  cini      = 1'b1;
                  state_nxt = ST_FILL;
               end else begin
                  emit = (state == ST_PASS);
                  if (reof)
                     state_nxt = ST_CHECK;
                  else if (state == ST_FILL && len == LEN_W'(FCS_LEN - 1))
                     state_nxt = ST_PASS;
               end
            end
         end
         ST_CHECK: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign cdat = rdat;
   assign chld = !cval & !cini;

   coremacfilter_fcsdly u_dly (
      .cclk     (cclk),
      .crstn    (crstn),
      .shift    (push & xcen),
      .dat      (rdat),
      .sof      (restart),
      .tail_dat (tail_dat),
      .tail_sof (tail_sof)
   );

   // An aborted frame reports one edge after the abort, using the length captured then.
   assign stat_fire = (state == ST_CHECK) | pend;
   assign stat_len  = pend ? pend_len : len;

   always_ff @(posedge cclk) begin
      if (!crstn) begin
         len      <= '0;
         pend     <= 1'b0;
         pend_len <= '0;
         odat     <= '0;
         oval     <= 1'b0;
         osof     <= 1'b0;
         oeof     <= 1'b0;
         sval     <= 1'b0;
         scrc     <= 1'b0;
         srnt     <= 1'b0;
         slng     <= 1'b0;
         sabt     <= 1'b0;
         slen     <= '0;
      end else if (xcen) begin
         oval <= emit;
         osof <= emit & tail_sof;
         oeof <= emit & reof;
         if (emit) odat <= tail_dat;

         if (restart)                    len <= LEN_W'(1);
         else if (push && len != LEN_SAT) len <= len + LEN_W'(1);

         pend <= abort;
         if (abort) pend_len <= len;

         sval <= stat_fire;
         if (stat_fire) begin
            scrc <= (state == ST_CHECK) & cerr;
            sabt <= pend;
            slen <= stat_len;
            srnt <= 32'(stat_len) < MINLEN;
            slng <= 32'(stat_len) > MAXLEN;
         end
      end
   end

endmodule

// File: tb/tb_coremacfilter_fcsstrip.sv
// Scoreboard bench: frames built with a CRC-32 model, expectations queued per frame,
// a monitor pops and compares payload bytes and status pulses.
module tb_coremacfilter_fcsstrip;

   typedef logic [7:0] bq_t[$];

   logic        cclk = 1'b0, crstn = 1'b0, xcen = 1'b0;
   logic [7:0]  rdat = '0;
   logic        rval = 1'b0, rsof = 1'b0, reof = 1'b0;
   logic [7:0]  cdat, odat;
   logic        cval, cini, chld, cerr;
   logic        oval, osof, oeof, sval, scrc, srnt, slng, sabt;
   logic [10:0] slen;

   int          n_vec = 0, n_err = 0;
   bit          xrand = 1'b0;
   logic        xen_edge = 1'b0, rst_edge = 1'b0;
   logic [31:0] eng = 32'h0;
   logic [9:0]  exp_d[$];
   logic [14:0] exp_s[$];

   always #5 cclk = ~cclk;

   coremacfilter_fcsstrip dut (
      .cclk(cclk), .crstn(crstn), .xcen(xcen), .rdat(rdat), .rval(rval),
      .rsof(rsof), .reof(reof), .cdat(cdat), .cval(cval), .cini(cini),
      .chld(chld), .cerr(cerr), .odat(odat), .oval(oval), .osof(osof),
      .oeof(oeof), .sval(sval), .scrc(scrc), .srnt(srnt), .slng(slng),
      .sabt(sabt), .slen(slen)
   );

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Behavioural external CRC engine; residue of a good frame is DEBB20E3.
   always @(posedge cclk) begin
      if (xcen) begin
         if (cval)      eng <= crc_upd(cini ? 32'hFFFFFFFF : eng, cdat);
         else if (cini) eng <= 32'hFFFFFFFF;
      end
   end
   assign cerr = (eng != 32'hDEBB20E3);

   always @(posedge cclk) begin
      xen_edge <= xcen;
      rst_edge <= crstn;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge cclk) begin
      if (xen_edge && rst_edge) begin
         if (oval) begin
            if (exp_d.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL odata: unexpected byte %h at %0t", odat, $time);
            end else chk("odata{sof,eof,dat}", 32'({osof, oeof, odat}), 32'(exp_d.pop_front()));
         end
         if (sval) begin
            if (exp_s.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL status: unexpected sval len %0d at %0t", slen, $time);
            end else chk("status{crc,rnt,lng,abt,len}", 32'({scrc, srnt, slng, sabt, slen}),
                         32'(exp_s.pop_front()));
         end
      end
   end

   function automatic bq_t make_frame(input int n, input int corrupt);
      bq_t         f;
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n - 4; i++) begin
         f.push_back(8'($urandom));
         c = crc_upd(c, f[i]);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
      if (corrupt >= 0) f[corrupt] = f[corrupt] ^ 8'h01;
      return f;
   endfunction

   task automatic expect_data(input bq_t f, input int nsent, input bit done);
      for (int i = 0; i < nsent - 4; i++)
         exp_d.push_back({i == 0, done && (i == nsent - 5), f[i]});
   endtask

   task automatic expect_stat(input int n, input bit crc, input bit abt);
      int l;
      l = (n > 2047) ? 2047 : n;
      exp_s.push_back({crc, l < 64, l > 1518, abt, 11'(l)});
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic s, input logic e);
      do begin
         @(negedge cclk);
         rval = v; rdat = d; rsof = s; reof = e;
         xcen = xrand ? ($urandom_range(3) != 0) : 1'b1;
      end while (!xcen);
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) begin
         step(1'($urandom), 8'($urandom), 1'b0, 1'($urandom));
         #1;
         if (j == 1) chk("cini_idle", 32'(cini), 32'(1));
      end
   endtask

   task automatic drive(input bq_t f, input int cnt, input bit eof, input int gap);
      for (int i = 0; i < cnt; i++) begin
         step(1'b1, f[i], i == 0, eof && (i == cnt - 1));
         #1 chk("cval_byte", 32'(cval), 32'(1));
         if (i != cnt - 1)
            for (int g = 0; g < gap; g++) begin
               step(1'b0, 8'($urandom), 1'b0, 1'b0);
               #1 chk("chld_gap", 32'(chld), 32'(1));
            end
      end
   endtask

   task automatic run_frame(input int n, input int corrupt, input int gap);
      bq_t f;
      f = make_frame(n, corrupt);
      expect_data(f, n, 1'b1);
      expect_stat(n, corrupt >= 0, 1'b0);
      drive(f, n, 1'b1, gap);
      idle(2);
   endtask

   task automatic do_reset();
      @(negedge cclk);
      crstn = 1'b0; xcen = 1'b0; rval = 1'b0; rsof = 1'b0; reof = 1'b0;
      @(negedge cclk);
      chk("reset_outputs", 32'({odat, oval, osof, oeof, sval, scrc, srnt, slng, sabt, slen}), 32'(0));
      crstn = 1'b1;
   endtask

   initial begin
      #900000;
      $display("FAIL timeout: simulation bound expired");
      $fatal(1, "timeout");
   end

   initial begin
      bq_t fa, fb;
      repeat (3) @(negedge cclk);
      chk("reset_outputs", 32'({odat, oval, osof, oeof, sval, scrc, srnt, slng, sabt, slen}), 32'(0));
      crstn = 1'b1;
      idle(2);

      run_frame(64, -1, 0);
      run_frame(64, 10, 0);
      run_frame(4, -1, 0);
      run_frame(1519, -1, 0);
      run_frame(64, -1, 3);

      // New frame started by rsof at byte 20 of the current one.
      fa = make_frame(64, -1);
      fb = make_frame(64, -1);
      expect_data(fa, 20, 1'b0);
      expect_stat(20, 1'b0, 1'b1);
      expect_data(fb, 64, 1'b1);
      expect_stat(64, 1'b0, 1'b0);
      drive(fa, 20, 1'b0, 0);
      drive(fb, 64, 1'b1, 0);
      idle(2);

      // Reset after 30 bytes: bytes already emitted are seen, no status.
      fa = make_frame(64, -1);
      expect_data(fa, 30, 1'b0);
      drive(fa, 30, 1'b0, 0);
      do_reset();
      idle(2);
      run_frame(64, -1, 0);

      xrand = 1'b1;
      for (int k = 0; k < 24; k++) begin
         int n, c;
         n = $urandom_range(300, 4);
         c = ($urandom_range(2) == 0) ? $urandom_range(n - 1, 0) : -1;
         run_frame(n, c, $urandom_range(2));
      end
      xrand = 1'b0;

      for (int i = 0; i < 300 && (exp_d.size() != 0 || exp_s.size() != 0); i++) @(negedge cclk);
      chk("drain_data", 32'(exp_d.size()), 32'(0));
      chk("drain_status", 32'(exp_s.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
